// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit for the 8-bit CPU datapath.
// Sequences fetch / operand fetch / execute / writeback and drives all
// datapath strobes combinationally from the current state and IR.
// Only state, retired counter, halted and illegal are registered.
module cpu_ctrl_fsm #(
    parameter int RETIRE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          ir,
    input  logic                rd_zero,
    input  logic                imem_ready,
    output logic                imem_req,
    output logic                ir_load,
    output logic                imm_load,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                rf_we,
    output logic [1:0]          rf_wsel,
    output logic [1:0]          rf_rsel_a,
    output logic [1:0]          rf_rsel_b,
    output logic [2:0]          alu_op,
    output logic                wb_src,
    output logic                led_we,
    output logic                halted,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_FETCH2 = 3'd3,
        S_EXEC   = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_OUT  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BEQZ = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t     state, state_nxt;
    logic [3:0] opcode;
    logic       op_illegal;
    logic [2:0] alu_dec;
    logic       retire_evt;
    logic       halt_evt;
    logic       ill_evt;

    assign opcode     = ir[7:4];
    assign op_illegal = (opcode >= 4'hA) && (opcode <= 4'hE);
    assign state_dbg  = state;

    // ALU function for the arithmetic/logic opcodes; MOV routes port B through
    always_comb begin
        alu_dec = 3'd0;
        case (opcode)
            4'h1:    alu_dec = 3'd0;
            4'h2:    alu_dec = 3'd1;
            4'h3:    alu_dec = 3'd2;
            4'h4:    alu_dec = 3'd3;
            4'h5:    alu_dec = 3'd4;
            default: alu_dec = 3'd0;
        endcase
    end

    // Next-state and strobe decode
    always_comb begin
        state_nxt  = state;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        imm_load   = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        rf_we      = 1'b0;
        rf_wsel    = 2'd0;
        rf_rsel_a  = 2'd0;
        rf_rsel_b  = 2'd0;
        alu_op     = 3'd0;
        wb_src     = 1'b0;
        led_we     = 1'b0;
        retire_evt = 1'b0;
        halt_evt   = 1'b0;
        ill_evt    = 1'b0;

        // Register indices follow IR whenever the CPU is live
        if (state != S_RST && state != S_HALT && state != S_BAD) begin
            rf_rsel_a = ir[3:2];
            rf_rsel_b = ir[1:0];
            rf_wsel   = ir[3:2];
        end

        case (state)
            S_RST: state_nxt = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load   = 1'b1;
                    pc_inc    = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LDI, OP_JMP, OP_BEQZ: state_nxt = S_FETCH2;
                    OP_HALT: begin
                        state_nxt  = S_HALT;
                        retire_evt = 1'b1;
                        halt_evt   = 1'b1;
                    end
                    default: state_nxt = S_EXEC;
                endcase
            end
            S_FETCH2: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    imm_load  = 1'b1;
                    pc_inc    = 1'b1;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op = alu_dec;
                wb_src = (opcode == OP_LDI);
                case (opcode)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, OP_LDI: state_nxt = S_WB;
                    OP_OUT: begin
                        led_we     = 1'b1;
                        state_nxt  = S_FETCH;
                        retire_evt = 1'b1;
                    end
                    OP_JMP: begin
                        pc_load    = 1'b1;
                        state_nxt  = S_FETCH;
                        retire_evt = 1'b1;
                    end
                    OP_BEQZ: begin
                        pc_load    = rd_zero;
                        state_nxt  = S_FETCH;
                        retire_evt = 1'b1;
                    end
                    OP_NOP: begin
                        state_nxt  = S_FETCH;
                        retire_evt = 1'b1;
                    end
                    default: begin
                        // Undefined opcodes retire as NOPs but flag the event
                        ill_evt    = op_illegal;
                        state_nxt  = S_FETCH;
                        retire_evt = 1'b1;
                    end
                endcase
            end
            S_WB: begin
                rf_we      = 1'b1;
                alu_op     = alu_dec;
                wb_src     = (opcode == OP_LDI);
                state_nxt  = S_FETCH;
                retire_evt = 1'b1;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_RST;
        endcase
    end

    // State register, retire counter and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_RST;
            retired <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nxt;
            illegal <= ill_evt;
            if (retire_evt)
                retired <= retired + RETIRE_W'(1);
            if (halt_evt)
                halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Table-driven bench for cpu_ctrl_fsm: per-cycle vectors of inputs and
// expected outputs, queued on drive and checked on the falling edge,
// plus hand sequences for reset, halt and counter wrap.
module tb_cpu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ir;
    logic       rd_zero;
    logic       imem_ready;
    logic       imem_req, ir_load, imm_load, pc_inc, pc_load, rf_we;
    logic [1:0] rf_wsel, rf_rsel_a, rf_rsel_b;
    logic [2:0] alu_op;
    logic       wb_src, led_we, halted, illegal;
    logic [7:0] retired;
    logic [2:0] state_dbg;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [2:0] F = 3'd1, D = 3'd2, F2 = 3'd3, E = 3'd4, W = 3'd5, H = 3'd6;

    typedef struct {
        logic [7:0] ir;
        logic       rdy;
        logic       rz;
        logic [2:0] st;
        logic [5:0] strb;  // req, ir_load, imm_load, pc_inc, pc_load, rf_we
        logic [2:0] alu;
        logic       wbs;
        logic       led;
        logic       ill;
        logic       hlt;
        logic [7:0] ret;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    cpu_ctrl_fsm #(.RETIRE_W(8)) dut (
        .clk(clk), .reset(reset), .ir(ir), .rd_zero(rd_zero), .imem_ready(imem_ready),
        .imem_req(imem_req), .ir_load(ir_load), .imm_load(imm_load), .pc_inc(pc_inc),
        .pc_load(pc_load), .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_rsel_a(rf_rsel_a),
        .rf_rsel_b(rf_rsel_b), .alu_op(alu_op), .wb_src(wb_src), .led_we(led_we),
        .halted(halted), .illegal(illegal), .retired(retired), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    logic [29:0] act_pack;
    assign act_pack = {state_dbg, imem_req, ir_load, imm_load, pc_inc, pc_load, rf_we,
                       alu_op, wb_src, led_we, illegal, halted, retired,
                       rf_wsel, rf_rsel_a, rf_rsel_b};

    function automatic vec_t mk(logic [7:0] i, logic rdy, logic rz, logic [2:0] st,
                                logic [5:0] strb, logic [2:0] alu, logic wbs, logic led,
                                logic ill, logic hlt, logic [7:0] ret);
        vec_t v;
        v.ir = i; v.rdy = rdy; v.rz = rz; v.st = st; v.strb = strb; v.alu = alu;
        v.wbs = wbs; v.led = led; v.ill = ill; v.hlt = hlt; v.ret = ret;
        return v;
    endfunction

    function automatic logic [29:0] exp_pack(vec_t v);
        logic [5:0] sel;
        sel = (v.st == 3'd0 || v.st == H) ? 6'd0 : {v.ir[3:2], v.ir[3:2], v.ir[1:0]};
        return {v.st, v.strb, v.alu, v.wbs, v.led, v.ill, v.hlt, v.ret, sel};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare on the falling edge
    task automatic apply(input vec_t v, input string name);
        vec_t e;
        @(posedge clk);
        #1;
        ir = v.ir; imem_ready = v.rdy; rd_zero = v.rz;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk(name, {2'b0, act_pack}, {2'b0, exp_pack(e)});
    endtask

    initial begin
        reset = 1'b1; ir = 8'h00; rd_zero = 1'b0; imem_ready = 1'b1;

        // LDI R1 ; LDI R2 ; ADD R2,R1
        tbl.push_back(mk(8'h00,1,0,F ,6'b110100,0,0,0,0,0,0));
        tbl.push_back(mk(8'h64,1,0,D ,6'b000000,0,0,0,0,0,0));
        tbl.push_back(mk(8'h64,1,0,F2,6'b101100,0,0,0,0,0,0));
        tbl.push_back(mk(8'h64,1,0,E ,6'b000000,0,1,0,0,0,0));
        tbl.push_back(mk(8'h64,1,0,W ,6'b000001,0,1,0,0,0,0));
        tbl.push_back(mk(8'h64,1,0,F ,6'b110100,0,0,0,0,0,1));
        tbl.push_back(mk(8'h68,1,0,D ,6'b000000,0,0,0,0,0,1));
        tbl.push_back(mk(8'h68,1,0,F2,6'b101100,0,0,0,0,0,1));
        tbl.push_back(mk(8'h68,1,0,E ,6'b000000,0,1,0,0,0,1));
        tbl.push_back(mk(8'h68,1,0,W ,6'b000001,0,1,0,0,0,1));
        tbl.push_back(mk(8'h68,1,0,F ,6'b110100,0,0,0,0,0,2));
        tbl.push_back(mk(8'h19,1,0,D ,6'b000000,0,0,0,0,0,2));
        tbl.push_back(mk(8'h19,1,0,E ,6'b000000,0,0,0,0,0,2));
        tbl.push_back(mk(8'h19,1,0,W ,6'b000001,0,0,0,0,0,2));
        tbl.push_back(mk(8'h19,1,0,F ,6'b110100,0,0,0,0,0,3));
        // BEQZ taken, then not taken
        tbl.push_back(mk(8'h90,1,1,D ,6'b000000,0,0,0,0,0,3));
        tbl.push_back(mk(8'h90,1,1,F2,6'b101100,0,0,0,0,0,3));
        tbl.push_back(mk(8'h90,1,1,E ,6'b000010,0,0,0,0,0,3));
        tbl.push_back(mk(8'h90,1,0,F ,6'b110100,0,0,0,0,0,4));
        tbl.push_back(mk(8'h90,1,0,D ,6'b000000,0,0,0,0,0,4));
        tbl.push_back(mk(8'h90,1,0,F2,6'b101100,0,0,0,0,0,4));
        tbl.push_back(mk(8'h90,1,0,E ,6'b000000,0,0,0,0,0,4));
        // FETCH stalled 5 cycles
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(8'h90,0,0,F ,6'b100000,0,0,0,0,0,5));
        tbl.push_back(mk(8'h90,1,0,F ,6'b110100,0,0,0,0,0,5));
        // Illegal opcode
        tbl.push_back(mk(8'hA0,1,0,D ,6'b000000,0,0,0,0,0,5));
        tbl.push_back(mk(8'hA0,1,0,E ,6'b000000,0,0,0,0,0,5));
        tbl.push_back(mk(8'hA0,1,0,F ,6'b110100,0,0,0,1,0,6));
        // SUB, AND, OR, MOV
        tbl.push_back(mk(8'h2E,1,0,D ,6'b000000,0,0,0,0,0,6));
        tbl.push_back(mk(8'h2E,1,0,E ,6'b000000,1,0,0,0,0,6));
        tbl.push_back(mk(8'h2E,1,0,W ,6'b000001,1,0,0,0,0,6));
        tbl.push_back(mk(8'h2E,1,0,F ,6'b110100,0,0,0,0,0,7));
        tbl.push_back(mk(8'h31,1,0,D ,6'b000000,0,0,0,0,0,7));
        tbl.push_back(mk(8'h31,1,0,E ,6'b000000,2,0,0,0,0,7));
        tbl.push_back(mk(8'h31,1,0,W ,6'b000001,2,0,0,0,0,7));
        tbl.push_back(mk(8'h31,1,0,F ,6'b110100,0,0,0,0,0,8));
        tbl.push_back(mk(8'h47,1,0,D ,6'b000000,0,0,0,0,0,8));
        tbl.push_back(mk(8'h47,1,0,E ,6'b000000,3,0,0,0,0,8));
        tbl.push_back(mk(8'h47,1,0,W ,6'b000001,3,0,0,0,0,8));
        tbl.push_back(mk(8'h47,1,0,F ,6'b110100,0,0,0,0,0,9));
        tbl.push_back(mk(8'h56,1,0,D ,6'b000000,0,0,0,0,0,9));
        tbl.push_back(mk(8'h56,1,0,E ,6'b000000,4,0,0,0,0,9));
        tbl.push_back(mk(8'h56,1,0,W ,6'b000001,4,0,0,0,0,9));
        tbl.push_back(mk(8'h56,1,0,F ,6'b110100,0,0,0,0,0,10));
        // OUT, JMP, NOP
        tbl.push_back(mk(8'h74,1,0,D ,6'b000000,0,0,0,0,0,10));
        tbl.push_back(mk(8'h74,1,0,E ,6'b000000,0,0,1,0,0,10));
        tbl.push_back(mk(8'h74,1,0,F ,6'b110100,0,0,0,0,0,11));
        tbl.push_back(mk(8'h80,1,0,D ,6'b000000,0,0,0,0,0,11));
        tbl.push_back(mk(8'h80,1,0,F2,6'b101100,0,0,0,0,0,11));
        tbl.push_back(mk(8'h80,1,0,E ,6'b000010,0,0,0,0,0,11));
        tbl.push_back(mk(8'h80,1,0,F ,6'b110100,0,0,0,0,0,12));
        tbl.push_back(mk(8'h00,1,0,D ,6'b000000,0,0,0,0,0,12));
        tbl.push_back(mk(8'h00,1,0,E ,6'b000000,0,0,0,0,0,12));
        tbl.push_back(mk(8'h00,1,0,F ,6'b110100,0,0,0,0,0,13));
        // JMP with FETCH2 stall
        tbl.push_back(mk(8'h80,1,0,D ,6'b000000,0,0,0,0,0,13));
        tbl.push_back(mk(8'h80,0,0,F2,6'b100000,0,0,0,0,0,13));
        tbl.push_back(mk(8'h80,1,0,F2,6'b101100,0,0,0,0,0,13));
        tbl.push_back(mk(8'h80,1,0,E ,6'b000010,0,0,0,0,0,13));
        tbl.push_back(mk(8'h80,1,0,F ,6'b110100,0,0,0,0,0,14));
        // HALT
        tbl.push_back(mk(8'hF0,1,0,D ,6'b000000,0,0,0,0,0,14));
        tbl.push_back(mk(8'hF0,1,0,H ,6'b000000,0,0,0,0,1,15));

        // Reset held 200 ns: everything quiet
        repeat (20) @(negedge clk);
        chk("reset_quiet", {2'b0, act_pack}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_state_after_release", {2'b0, act_pack}, 32'd0);

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // HALT is absorbing regardless of inputs
        for (int i = 0; i < 50; i++)
            apply(mk(8'hF0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), H,
                     6'b000000, 0, 0, 0, 0, 1, 15), $sformatf("halt%0d", i));

        // Async reset out of HALT, mid-cycle
        @(posedge clk);
        #1 reset = 1'b1; ir = 8'h00; imem_ready = 1'b1; rd_zero = 1'b0;
        #1;
        chk("async_reset_clears", {2'b0, act_pack}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_state2", {29'd0, state_dbg}, 32'd0);
        @(posedge clk);
        #1;
        chk("fetch_after_rst", {28'd0, state_dbg, imem_req}, {28'd0, F, 1'b1});

        // 256 NOPs at 3 cycles each: counter wraps FF -> 00
        repeat (3 * 255) @(posedge clk);
        #1;
        chk("retired_ff", {21'd0, state_dbg, retired}, {21'd0, F, 8'hFF});
        repeat (3) @(posedge clk);
        #1;
        chk("retired_wrap", {21'd0, state_dbg, retired}, {21'd0, F, 8'h00});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
